// File: rtl/int_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: state encoding, vectors, stack page, P bit layout.
package int_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_PCH = 3'd1,
    ST_PUSH_PCL = 3'd2,
    ST_PUSH_P   = 3'd3,
    ST_VEC_LO   = 3'd4,
    ST_VEC_HI   = 3'd5
  } state_t;

  localparam logic [15:0] VEC_NMI    = 16'hFFFA;
  localparam logic [15:0] VEC_RESET  = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ    = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE = 8'h01;
  localparam int          P_BIT_B    = 4;
  localparam int          P_BIT_U    = 5;

  // Status byte as it lands on the stack: U always set, B marks a software break.
  function automatic logic [7:0] pushed_p(input logic [7:0] p, input logic brk);
    logic [7:0] v;
    v          = p;
    v[P_BIT_U] = 1'b1;
    v[P_BIT_B] = brk;
    return v;
  endfunction

endpackage

// File: rtl/int_sequencer_nmi_edge_detect.sv
// NMI rising-edge detector with a pending latch; a new edge wins over a same-cycle clear.
module nmi_edge_detect (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_nmi,
  input  logic i_clear,
  output logic o_pending
);

  logic r_nmi_prev;
  logic r_pending;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_nmi_prev <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      r_nmi_prev <= i_nmi;
      if (i_nmi && !r_nmi_prev)
        r_pending <= 1'b1;
      else if (i_clear)
        r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/int_sequencer.sv
// Interrupt/BRK/reset entry sequencer: pushes PCH, PCL, P then fetches the vector.
// Define INT_NMI_EN to enable NMI edge detection, pending latch and vector hijack.
module int_sequencer
  import int_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IRQ,
  input  logic        NMI,
  input  logic        BRK_REQ,
  input  logic        INSTR_DONE,
  input  logic        FLAG_I,
  input  logic [7:0]  PCH_IN,
  input  logic [7:0]  PCL_IN,
  input  logic [7:0]  P_IN,
  input  logic [7:0]  SP_IN,
  input  logic [7:0]  DATA_IN,
  output logic [15:0] ADDR,
  output logic [7:0]  DATA_OUT,
  output logic        read,
  output logic        write,
  output logic        dec_SP,
  output logic        load_PCL,
  output logic        load_PCH,
  output logic        set_I,
  output logic        BUSY
);

  state_t      r_state;
  logic [15:0] r_vec;
  logic        r_brk;
  logic        w_nmi_pending;

`ifdef INT_NMI_EN
  logic w_nmi_clear;

  assign w_nmi_clear = (r_state == ST_VEC_LO) && (r_vec == VEC_NMI) && !RESET;

  nmi_edge_detect u_nmi_edge_detect (
    .i_clk     (CLK),
    .i_srst    (RESET),
    .i_nmi     (NMI),
    .i_clear   (w_nmi_clear),
    .o_pending (w_nmi_pending)
  );
`else
  assign w_nmi_pending = NMI & 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_VEC_LO;
      r_vec   <= VEC_RESET;
      r_brk   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (INSTR_DONE) begin
            if (w_nmi_pending) begin
              r_state <= ST_PUSH_PCH;
              r_vec   <= VEC_NMI;
              r_brk   <= 1'b0;
            end else if (BRK_REQ) begin
              r_state <= ST_PUSH_PCH;
              r_vec   <= VEC_IRQ;
              r_brk   <= 1'b1;
            end else if (IRQ && !FLAG_I) begin
              r_state <= ST_PUSH_PCH;
              r_vec   <= VEC_IRQ;
              r_brk   <= 1'b0;
            end
          end
        end
        ST_PUSH_PCH: r_state <= ST_PUSH_PCL;
        ST_PUSH_PCL: r_state <= ST_PUSH_P;
        ST_PUSH_P: begin
          r_state <= ST_VEC_LO;
          // Late NMI steals the vector; the B bit already on the stack is left alone.
          if (w_nmi_pending)
            r_vec <= VEC_NMI;
        end
        ST_VEC_LO: r_state <= ST_VEC_HI;
        ST_VEC_HI: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ADDR     = 16'h0000;
    DATA_OUT = 8'h00;
    read     = 1'b0;
    write    = 1'b0;
    dec_SP   = 1'b0;
    load_PCL = 1'b0;
    load_PCH = 1'b0;
    set_I    = 1'b0;
    if (!RESET) begin
      case (r_state)
        ST_PUSH_PCH: begin
          ADDR     = {STACK_PAGE, SP_IN};
          DATA_OUT = PCH_IN;
          write    = 1'b1;
          dec_SP   = 1'b1;
        end
        ST_PUSH_PCL: begin
          ADDR     = {STACK_PAGE, SP_IN};
          DATA_OUT = PCL_IN;
          write    = 1'b1;
          dec_SP   = 1'b1;
        end
        ST_PUSH_P: begin
          ADDR     = {STACK_PAGE, SP_IN};
          DATA_OUT = pushed_p(P_IN, r_brk);
          write    = 1'b1;
          dec_SP   = 1'b1;
        end
        ST_VEC_LO: begin
          ADDR     = r_vec;
          DATA_OUT = DATA_IN;
          read     = 1'b1;
          load_PCL = 1'b1;
          set_I    = 1'b1;
        end
        ST_VEC_HI: begin
          ADDR     = r_vec + 16'd1;
          DATA_OUT = DATA_IN;
          read     = 1'b1;
          load_PCH = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (r_state != ST_IDLE);

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: models the vector ROM and the caller's SP decrement.
module tb_int_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IRQ = 1'b0, NMI = 1'b0, BRK_REQ = 1'b0, INSTR_DONE = 1'b0, FLAG_I = 1'b0;
  logic [7:0]  PCH_IN = 8'h00, PCL_IN = 8'h00, P_IN = 8'h00, SP_IN = 8'hFF;
  logic [7:0]  DATA_IN;
  logic [15:0] ADDR;
  logic [7:0]  DATA_OUT;
  logic        read, write, dec_SP, load_PCL, load_PCH, set_I, BUSY;

  int total = 0;
  int bad = 0;

  int          n_wr, n_busy, n_pcl, n_pch, n_seti, n_strb, idle_bad;
  logic [71:0] wr_sig;
  logic [31:0] rd_sig;
  logic [7:0]  pcl_val, pch_val;
  logic        last_busy;
  logic [5:0]  last_strb;

  int_sequencer dut (
    .CLK(CLK), .RESET(RESET), .IRQ(IRQ), .NMI(NMI), .BRK_REQ(BRK_REQ),
    .INSTR_DONE(INSTR_DONE), .FLAG_I(FLAG_I),
    .PCH_IN(PCH_IN), .PCL_IN(PCL_IN), .P_IN(P_IN), .SP_IN(SP_IN), .DATA_IN(DATA_IN),
    .ADDR(ADDR), .DATA_OUT(DATA_OUT),
    .read(read), .write(write), .dec_SP(dec_SP), .load_PCL(load_PCL),
    .load_PCH(load_PCH), .set_I(set_I), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Vector ROM: NMI=5678, RESET=1234, IRQ/BRK=9ABC
  always_comb begin
    DATA_IN = 8'h00;
    if (read) begin
      case (ADDR)
        16'hFFFA: DATA_IN = 8'h78;
        16'hFFFB: DATA_IN = 8'h56;
        16'hFFFC: DATA_IN = 8'h34;
        16'hFFFD: DATA_IN = 8'h12;
        16'hFFFE: DATA_IN = 8'hBC;
        16'hFFFF: DATA_IN = 8'h9A;
        default:  DATA_IN = 8'h00;
      endcase
    end
  end

  task automatic clear_log();
    n_wr = 0; n_busy = 0; n_pcl = 0; n_pch = 0; n_seti = 0; n_strb = 0; idle_bad = 0;
    wr_sig = '0; rd_sig = '0; pcl_val = 8'h00; pch_val = 8'h00;
  endtask

  task automatic cycle();
    logic dec;
    logic [5:0] strb;
    @(negedge CLK);
    strb      = {read, write, dec_SP, load_PCL, load_PCH, set_I};
    last_busy = BUSY;
    last_strb = strb;
    if (BUSY === 1'b1) n_busy++;
    if (strb !== 6'b0) n_strb++;
    if (write === 1'b1) begin
      n_wr++;
      wr_sig = {wr_sig[47:0], ADDR, DATA_OUT};
      $display("  bus write addr=%h data=%h", ADDR, DATA_OUT);
    end
    if (read === 1'b1) begin
      rd_sig = {rd_sig[15:0], ADDR};
      $display("  bus read  addr=%h data=%h", ADDR, DATA_OUT);
    end
    if (load_PCL === 1'b1) begin n_pcl++; pcl_val = DATA_OUT; end
    if (load_PCH === 1'b1) begin n_pch++; pch_val = DATA_OUT; end
    if (set_I === 1'b1) n_seti++;
    if (BUSY === 1'b0 && (ADDR !== 16'h0 || DATA_OUT !== 8'h0 || strb !== 6'b0)) idle_bad++;
    dec = dec_SP;
    @(posedge CLK);
    #1;
    if (dec === 1'b1) SP_IN = SP_IN - 8'd1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    run_cycles(3);
    total++;
    if (last_busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", last_busy); end
    total++;
    if (last_strb !== 6'b0) begin bad++; $display("FAIL reset_strobes got=%b want=000000", last_strb); end
    clear_log();
    RESET = 1'b0;
    run_cycles(4);
    $display("reset release: reads=%h pcl=%h pch=%h busy_cycles=%0d", rd_sig, pcl_val, pch_val, n_busy);
    total++;
    if (rd_sig !== 32'hFFFCFFFD) begin bad++; $display("FAIL reset_reads got=%h want=FFFCFFFD", rd_sig); end
    total++;
    if ({n_pcl[7:0], pcl_val, n_pch[7:0], pch_val} !== 32'h01340112) begin
      bad++; $display("FAIL reset_pc_load got=%0d/%h %0d/%h want=1/34 1/12", n_pcl, pcl_val, n_pch, pch_val);
    end
    total++;
    if (n_wr !== 0) begin bad++; $display("FAIL reset_writes got=%0d want=0", n_wr); end
    total++;
    if (n_busy !== 2) begin bad++; $display("FAIL reset_busy_cycles got=%0d want=2", n_busy); end
    total++;
    if (idle_bad !== 0) begin bad++; $display("FAIL reset_idle_outputs got=%0d want=0", idle_bad); end
  endtask

  task automatic test_irq();
    PCH_IN = 8'h12; PCL_IN = 8'h34; P_IN = 8'h81; SP_IN = 8'hFD;
    IRQ = 1'b1; FLAG_I = 1'b0; INSTR_DONE = 1'b1;
    clear_log();
    run_cycles(1);
    INSTR_DONE = 1'b0;
    run_cycles(7);
    IRQ = 1'b0;
    $display("irq: writes=%h reads=%h busy_cycles=%0d", wr_sig, rd_sig, n_busy);
    total++;
    if (wr_sig !== {16'h01FD, 8'h12, 16'h01FC, 8'h34, 16'h01FB, 8'hA1}) begin
      bad++; $display("FAIL irq_pushes got=%h want=01FD1201FC3401FBA1", wr_sig);
    end
    total++;
    if (rd_sig !== 32'hFFFEFFFF) begin bad++; $display("FAIL irq_reads got=%h want=FFFEFFFF", rd_sig); end
    total++;
    if ({pch_val, pcl_val} !== 16'h9ABC) begin bad++; $display("FAIL irq_pc got=%h%h want=9ABC", pch_val, pcl_val); end
    total++;
    if (n_seti !== 1) begin bad++; $display("FAIL irq_set_i got=%0d want=1", n_seti); end
    total++;
    if (n_busy !== 5) begin bad++; $display("FAIL irq_busy_cycles got=%0d want=5", n_busy); end
    total++;
    if (SP_IN !== 8'hFA) begin bad++; $display("FAIL irq_sp_decs got=%h want=FA", SP_IN); end
    total++;
    if (idle_bad !== 0) begin bad++; $display("FAIL irq_idle_outputs got=%0d want=0", idle_bad); end
  endtask

  task automatic test_irq_masked();
    IRQ = 1'b1; FLAG_I = 1'b1; INSTR_DONE = 1'b1;
    clear_log();
    run_cycles(1);
    INSTR_DONE = 1'b0;
    run_cycles(6);
    IRQ = 1'b0; FLAG_I = 1'b0;
    $display("irq masked: busy_cycles=%0d strobe_cycles=%0d", n_busy, n_strb);
    total++;
    if (n_busy !== 0) begin bad++; $display("FAIL masked_busy got=%0d want=0", n_busy); end
    total++;
    if (n_strb !== 0) begin bad++; $display("FAIL masked_strobes got=%0d want=0", n_strb); end
  endtask

  task automatic test_brk();
    // SP=00 also checks the stack address is built straight from SP_IN.
    PCH_IN = 8'hA5; PCL_IN = 8'h5A; P_IN = 8'h00; SP_IN = 8'h00;
    BRK_REQ = 1'b1; FLAG_I = 1'b1; INSTR_DONE = 1'b1;
    clear_log();
    run_cycles(1);
    INSTR_DONE = 1'b0; BRK_REQ = 1'b0;
    run_cycles(7);
    FLAG_I = 1'b0;
    $display("brk: writes=%h reads=%h", wr_sig, rd_sig);
    total++;
    if (wr_sig !== {16'h0100, 8'hA5, 16'h01FF, 8'h5A, 16'h01FE, 8'h30}) begin
      bad++; $display("FAIL brk_pushes got=%h want=0100A501FF5A01FE30", wr_sig);
    end
    total++;
    if (rd_sig !== 32'hFFFEFFFF) begin bad++; $display("FAIL brk_reads got=%h want=FFFEFFFF", rd_sig); end
  endtask

`ifdef INT_NMI_EN
  task automatic test_nmi();
    // IRQ accepted, NMI edge during PUSH_PCL hijacks the vector.
    PCH_IN = 8'h12; PCL_IN = 8'h34; P_IN = 8'h81; SP_IN = 8'hFD; NMI = 1'b0;
    IRQ = 1'b1; INSTR_DONE = 1'b1;
    clear_log();
    run_cycles(1);
    INSTR_DONE = 1'b0;
    run_cycles(1);
    NMI = 1'b1;
    run_cycles(6);
    IRQ = 1'b0;
    $display("nmi hijack: writes=%h reads=%h", wr_sig, rd_sig);
    total++;
    if (wr_sig[7:0] !== 8'hA1) begin bad++; $display("FAIL hijack_pushed_p got=%h want=A1", wr_sig[7:0]); end
    total++;
    if (rd_sig !== 32'hFFFAFFFB) begin bad++; $display("FAIL hijack_reads got=%h want=FFFAFFFB", rd_sig); end
    total++;
    if ({pch_val, pcl_val} !== 16'h5678) begin bad++; $display("FAIL hijack_pc got=%h%h want=5678", pch_val, pcl_val); end
    // Pending must be gone: a bare INSTR_DONE starts nothing.
    INSTR_DONE = 1'b1;
    clear_log();
    run_cycles(1);
    INSTR_DONE = 1'b0;
    run_cycles(3);
    total++;
    if (n_busy !== 0) begin bad++; $display("FAIL hijack_pending_cleared got=%0d want=0", n_busy); end
    // Fresh NMI while idle outranks a simultaneous BRK.
    NMI = 1'b0;
    run_cycles(1);
    NMI = 1'b1;
    run_cycles(1);
    P_IN = 8'h00; SP_IN = 8'h80; BRK_REQ = 1'b1; INSTR_DONE = 1'b1;
    clear_log();
    run_cycles(1);
    INSTR_DONE = 1'b0; BRK_REQ = 1'b0;
    run_cycles(6);
    NMI = 1'b0;
    $display("nmi over brk: writes=%h reads=%h", wr_sig, rd_sig);
    total++;
    if (wr_sig !== {16'h0180, 8'h12, 16'h017F, 8'h34, 16'h017E, 8'h20}) begin
      bad++; $display("FAIL nmi_prio_pushes got=%h want=018012017F34017E20", wr_sig);
    end
    total++;
    if (rd_sig !== 32'hFFFAFFFB) begin bad++; $display("FAIL nmi_prio_reads got=%h want=FFFAFFFB", rd_sig); end
  endtask
`else
  task automatic test_nmi();
    NMI = 1'b0;
    run_cycles(1);
    NMI = 1'b1;
    run_cycles(1);
    INSTR_DONE = 1'b1;
    clear_log();
    run_cycles(1);
    INSTR_DONE = 1'b0;
    run_cycles(3);
    $display("nmi disabled: busy_cycles=%0d", n_busy);
    total++;
    if (n_busy !== 0) begin bad++; $display("FAIL nmi_ignored got=%0d want=0", n_busy); end
    SP_IN = 8'hFD; IRQ = 1'b1; INSTR_DONE = 1'b1;
    clear_log();
    run_cycles(1);
    INSTR_DONE = 1'b0;
    run_cycles(6);
    IRQ = 1'b0; NMI = 1'b0;
    total++;
    if (rd_sig !== 32'hFFFEFFFF) begin bad++; $display("FAIL nmi_off_irq_reads got=%h want=FFFEFFFF", rd_sig); end
  endtask
`endif

  task automatic test_reset_mid();
    PCH_IN = 8'h12; PCL_IN = 8'h34; P_IN = 8'h81; SP_IN = 8'hFD;
    IRQ = 1'b1; INSTR_DONE = 1'b1;
    run_cycles(1);
    INSTR_DONE = 1'b0;
    run_cycles(1);
    RESET = 1'b1;
    IRQ = 1'b0;
    clear_log();
    run_cycles(2);
    RESET = 1'b0;
    run_cycles(4);
    $display("reset mid-sequence: writes=%0d reads=%h busy_cycles=%0d", n_wr, rd_sig, n_busy);
    total++;
    if (n_wr !== 0) begin bad++; $display("FAIL midreset_writes got=%0d want=0", n_wr); end
    total++;
    if (rd_sig !== 32'hFFFCFFFD) begin bad++; $display("FAIL midreset_reads got=%h want=FFFCFFFD", rd_sig); end
    total++;
    if (n_busy !== 4) begin bad++; $display("FAIL midreset_busy_cycles got=%0d want=4", n_busy); end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_irq();
    test_irq_masked();
    test_brk();
    test_nmi();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
